decode: RTL and testbench
=========================

# decode

Decode stage of the in-order front end of the OoO RISC-V core. It sits downstream of `fetch` and consumes its `instr_to_decode` / `pc_to_decode` / `valid` stream. It returns the `ready` that `fetch` stalls on. Instructions are buffered in a 2-entry queue, decoded as RV32I into register and immediate fields, and presented to rename through a registered valid/ready output. A branch redirect flushes everything in flight.

## Interface
Parameters:
- `T`, default `logic [31:0]`: instruction and PC word type; matches `fetch`.
- `DEPTH`, default 2: input queue entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `flush`  in  1  branch redirect; same cycle that `fetch` sees `take_branch`.
- `instr_in`  in  32  instruction from `fetch`.
- `pc_in`  in  32  PC of `instr_in`.
- `valid_in`  in  1  `fetch` has an instruction.
- `ready_out`  out  1  decode can accept an instruction; drives `fetch.ready`.
- `valid_out`  out  1  the decoded bundle is valid.
- `ready_in`  in  1  rename accepts the bundle.
- `pc_out`  out  32  PC of the bundle.
- `rd`, `rs1`, `rs2`  out  5 each  register indices.
- `imm`  out  32  sign-extended immediate.
- `alu_op`  out  4  `alu_op_t` from the package.
- `uses_rs1`, `uses_rs2`, `writes_rd`  out  1 each  operand and destination usage.
- `is_branch`, `is_jump`, `is_load`, `is_store`  out  1 each  instruction class.
- `illegal`  out  1  unrecognised opcode or funct field.

## Operation
- Input handshake: a transfer happens when `valid_in && ready_out` is high at the rising edge. `ready_out` is registered as `count != DEPTH`. It has no combinational path from `ready_in`, so a full queue deasserts ready even in a cycle where it pops.
- Queue: circular buffer with head and tail pointers that wrap modulo DEPTH, plus `count`. Push and pop in the same cycle leaves `count` unchanged.
- Decode: combinational from the queue head. Opcode, funct3 and funct7 map to `alu_op`.
- Immediates are built by format and always sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: `imm` = 0.
- Output register: loads the decoded head when `!valid_out || ready_in`, and the queue pops at the same time. If the queue is empty at that point, `valid_out` clears. While `valid_out && !ready_in`, every output holds stable.
- Illegal instructions: `illegal`=1, with `writes_rd`, `uses_rs1`, `uses_rs2` and all class flags at 0. The bundle still flows so that a later stage can raise the exception.
- rd=x0: `writes_rd` is forced to 0.
- Flush (synchronous):
  - At the next edge, `count`=0, pointers are 0 and `valid_out`=0.
  - A transfer offered in the flush cycle is dropped.
  - `ready_out` is 1 in the following cycle.

## Timing
- Latency: an instruction accepted at edge N drives `valid_out` high after edge N+1, provided the output register was free.
- Throughput: 1 instruction per cycle while rename holds `ready_in`=1.
- Reset values: `ready_out`=1, `valid_out`=0, `count`=0, and every data output is 0.
- Reset asserted mid-stream discards all entries immediately (asynchronous); no partial bundle survives.
- If flush and reset are both active, reset wins. Flush takes priority over push and pop.
- When `ready_in`=0 and the queue fills, `ready_out` falls one edge after the push that made the queue full.

## Structure
- Shared package `core_pkg`:
  - `alu_op_t` enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - Opcode localparams: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - `decoded_t` packed struct covering all decoded output fields.
- One sub-module, `instr_queue`: a parameterised circular buffer holding {pc, instr} with push, pop, flush, count, full and empty. The decode logic and output register live in `decode`.

## Test plan
- Reset, then `valid_in`=1, `instr_in`=0x00510093, `pc_in`=0x0, `ready_in`=1 -> two edges later: `valid_out`=1, `rd`=1, `rs1`=2, `imm`=5, `alu_op`=ADD, `writes_rd`=1, `pc_out`=0x0.
- `instr_in`=0xFE208EE3 (beq x1,x2,-4) at `pc_in`=0x100 -> `is_branch`=1, `rs1`=1, `rs2`=2, `imm`=0xFFFFFFFC, `writes_rd`=0.
- Hold `ready_in`=0 and stream 3 instructions -> `ready_out`=0 once `count`=2. Outputs stay stable. Releasing `ready_in` drains the instructions in order with no loss or duplication.
- Queue holding 2 instructions plus a valid output, then `flush`=1 for one cycle while `valid_in`=1 -> next cycle `valid_out`=0, `ready_out`=1, and the offered instruction never appears.
- `instr_in`=0xFFFFFFFF -> `illegal`=1 and every usage/class flag is 0. `instr_in`=0x00000013 (addi x0) -> `writes_rd`=0.
- Assert `reset` low mid-stream with `ready_in`=1 -> `valid_out` goes to 0 immediately without a clock edge. After release, the first new instruction decodes correctly.

Source files
------------

// File: rtl/core_pkg.sv
// Shared front-end types: ALU operations, RV32I opcodes, decoded bundle and the RV32I field decoder.
package core_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB
    } alu_op_t;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        alu_op_t         alu_op;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
        logic            is_branch;
        logic            is_jump;
        logic            is_load;
        logic            is_store;
        logic            illegal;
    } decoded_t;

    // Register fields are passed through raw; usage flags say which ones matter.
    function automatic decoded_t decode_instr(input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
        decoded_t        d;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        f3    = instr[14:12];
        f7    = instr[31:25];
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        d        = '0;
        d.pc     = pc;
        d.rd     = instr[11:7];
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.alu_op = ADD;
        case (instr[6:0])
            OP: begin
                d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: d.alu_op = ADD;
                    10'b0100000_000: d.alu_op = SUB;
                    10'b0000000_001: d.alu_op = SLL;
                    10'b0000000_010: d.alu_op = SLT;
                    10'b0000000_011: d.alu_op = SLTU;
                    10'b0000000_100: d.alu_op = XOR;
                    10'b0000000_101: d.alu_op = SRL;
                    10'b0100000_101: d.alu_op = SRA;
                    10'b0000000_110: d.alu_op = OR;
                    10'b0000000_111: d.alu_op = AND;
                    default:         d.illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.imm = imm_i;
                case (f3)
                    3'd0: d.alu_op = ADD;
                    3'd2: d.alu_op = SLT;
                    3'd3: d.alu_op = SLTU;
                    3'd4: d.alu_op = XOR;
                    3'd6: d.alu_op = OR;
                    3'd7: d.alu_op = AND;
                    3'd1: if (f7 == 7'h00) d.alu_op = SLL; else d.illegal = 1'b1;
                    default: begin
                        if (f7 == 7'h00)      d.alu_op = SRL;
                        else if (f7 == 7'h20) d.alu_op = SRA;
                        else                  d.illegal = 1'b1;
                    end
                endcase
            end
            LOAD: begin
                d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_load = 1'b1; d.imm = imm_i;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) d.illegal = 1'b1;
            end
            STORE: begin
                d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.is_store = 1'b1; d.imm = imm_s;
                if (f3 > 3'd2) d.illegal = 1'b1;
            end
            BRANCH: begin
                d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.is_branch = 1'b1; d.imm = imm_b;
                case (f3)
                    3'd0, 3'd1: d.alu_op = SUB;
                    3'd4, 3'd5: d.alu_op = SLT;
                    3'd6, 3'd7: d.alu_op = SLTU;
                    default:    d.illegal = 1'b1;
                endcase
            end
            JAL: begin
                d.writes_rd = 1'b1; d.is_jump = 1'b1; d.imm = imm_j;
            end
            JALR: begin
                d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_jump = 1'b1; d.imm = imm_i;
                if (f3 != 3'd0) d.illegal = 1'b1;
            end
            LUI: begin
                d.writes_rd = 1'b1; d.imm = imm_u; d.alu_op = PASSB;
            end
            AUIPC: begin
                d.writes_rd = 1'b1; d.imm = imm_u;
            end
            default: d.illegal = 1'b1;
        endcase
        // Illegal bundles carry no side effects; a later stage raises the exception.
        if (d.illegal) begin
            d.uses_rs1 = 1'b0; d.uses_rs2 = 1'b0; d.writes_rd = 1'b0;
            d.is_branch = 1'b0; d.is_jump = 1'b0; d.is_load = 1'b0; d.is_store = 1'b0;
            d.imm = '0; d.alu_op = ADD;
        end
        if (d.rd == 5'd0) d.writes_rd = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/instr_queue.sv
// Circular buffer of {pc, instr} pairs between fetch and the decode output register.
module instr_queue #(
    parameter type         T     = logic [31:0],
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  T                             push_pc,
    input  T                             push_instr,
    input  logic                         pop,
    output T                             head_pc_c,
    output T                             head_instr_c,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 pc_mem    [DEPTH];
    T                 instr_mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count_next;
    logic             do_push, do_pop;

    assign do_push      = push & ~full & ~flush;
    assign do_pop       = pop & ~empty & ~flush;
    assign head_pc_c    = pc_mem[head];
    assign head_instr_c = instr_mem[head];

    always_comb begin
        count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
        if (flush) count_next = '0;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (do_push) tail <= tail + PTR_W'(1);
                if (do_pop)  head <= head + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[tail]    <= push_pc;
            instr_mem[tail] <= push_instr;
        end
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: input queue, field decoder and registered valid/ready bundle to rename.
module decode
    import core_pkg::*;
#(
    parameter type         T     = logic [31:0],
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  T           instr_in,
    input  T           pc_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       valid_out,
    input  logic       ready_in,
    output T           pc_out,
    output logic [4:0] rd,
    output logic [4:0] rs1,
    output logic [4:0] rs2,
    output logic [31:0] imm,
    output alu_op_t    alu_op,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       writes_rd,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_load,
    output logic       is_store,
    output logic       illegal
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 head_pc_c, head_instr_c;
    logic [CNT_W-1:0] q_count;
    logic             q_full, q_empty;
    logic             load_c, push_c, pop_c;
    decoded_t         dec_c, bundle_q;

    // Ready comes straight from the registered full flag, never from ready_in.
    assign ready_out = ~q_full;
    assign load_c    = ~valid_out | ready_in;
    assign push_c    = valid_in & ready_out & ~flush;
    assign pop_c     = load_c & ~q_empty & ~flush;
    assign dec_c     = decode_instr(32'(head_instr_c), 32'(head_pc_c));

    instr_queue #(.T(T), .DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .push         (push_c),
        .push_pc      (pc_in),
        .push_instr   (instr_in),
        .pop          (pop_c),
        .head_pc_c    (head_pc_c),
        .head_instr_c (head_instr_c),
        .count        (q_count),
        .full         (q_full),
        .empty        (q_empty)
    );

    // Output register: holds while rename stalls, refills from the queue head otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            bundle_q  <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (load_c) begin
            valid_out <= (q_count != '0);
            if (!q_empty) bundle_q <= dec_c;
        end
    end

    assign pc_out    = T'(bundle_q.pc);
    assign rd        = bundle_q.rd;
    assign rs1       = bundle_q.rs1;
    assign rs2       = bundle_q.rs2;
    assign imm       = bundle_q.imm;
    assign alu_op    = bundle_q.alu_op;
    assign uses_rs1  = bundle_q.uses_rs1;
    assign uses_rs2  = bundle_q.uses_rs2;
    assign writes_rd = bundle_q.writes_rd;
    assign is_branch = bundle_q.is_branch;
    assign is_jump   = bundle_q.is_jump;
    assign is_load   = bundle_q.is_load;
    assign is_store  = bundle_q.is_store;
    assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: field decode table, throughput, backpressure, flush and async reset.
module tb_decode;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, valid_in, ready_in;
    logic [31:0] instr_in, pc_in, pc_out, imm;
    logic        ready_out, valid_out;
    logic [4:0]  rd, rs1, rs2;
    alu_op_t     alu_op;
    logic        uses_rs1, uses_rs2, writes_rd, is_branch, is_jump, is_load, is_store, illegal;
    logic [7:0]  flags;
    int          n_checks = 0;
    int          n_fail = 0;

    assign flags = {illegal, uses_rs1, uses_rs2, writes_rd, is_branch, is_jump, is_load, is_store};

    always #5 clk = ~clk;

    decode u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in), .ready_out(ready_out),
        .valid_out(valid_out), .ready_in(ready_in), .pc_out(pc_out),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd),
        .is_branch(is_branch), .is_jump(is_jump), .is_load(is_load), .is_store(is_store),
        .illegal(illegal)
    );

    // Hand-decoded vectors; flags = {illegal, uses_rs1, uses_rs2, writes_rd, br, jmp, ld, st}.
    localparam logic [31:0] V_INSTR [10] = '{32'h00510093, 32'hFE208EE3, 32'hFE20AC23, 32'h008000EF,
        32'h123452B7, 32'h402081B3, 32'hFFFFFFFF, 32'h00000013, 32'h00C12303, 32'h4030D093};
    localparam logic [4:0]  V_RD   [10] = '{5'd1, 5'd29, 5'd24, 5'd1, 5'd5, 5'd3, 5'd31, 5'd0, 5'd6, 5'd1};
    localparam logic [4:0]  V_RS1  [10] = '{5'd2, 5'd1, 5'd1, 5'd0, 5'd8, 5'd1, 5'd31, 5'd0, 5'd2, 5'd1};
    localparam logic [4:0]  V_RS2  [10] = '{5'd5, 5'd2, 5'd2, 5'd8, 5'd3, 5'd2, 5'd31, 5'd0, 5'd12, 5'd3};
    localparam logic [31:0] V_IMM  [10] = '{32'h5, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h8, 32'h12345000,
        32'h0, 32'h0, 32'h0, 32'hC, 32'h403};
    localparam logic [3:0]  V_ALU  [10] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd10, 4'd1, 4'd0, 4'd0, 4'd0, 4'd7};
    localparam logic [7:0]  V_FLG  [10] = '{8'h50, 8'h68, 8'h61, 8'h14, 8'h10, 8'h70, 8'h80, 8'h40, 8'h52, 8'h50};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one instruction and hold it until fetch would see it accepted.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        logic acc;
        acc      = 1'b0;
        valid_in = 1'b1;
        instr_in = ins;
        pc_in    = pc;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = ready_out;
            tick();
        end
        valid_in = 1'b0;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        instr_in = '0; pc_in = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_pc", pc_out, 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Decode table, one instruction at a time with rename ready.
        ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(V_INSTR[i], 32'h100 * i);
            tick();
            check($sformatf("v%0d_valid", i), 32'(valid_out), 32'd1);
            check($sformatf("v%0d_pc", i), pc_out, 32'h100 * i);
            check($sformatf("v%0d_rd", i), 32'(rd), 32'(V_RD[i]));
            check($sformatf("v%0d_rs1", i), 32'(rs1), 32'(V_RS1[i]));
            check($sformatf("v%0d_rs2", i), 32'(rs2), 32'(V_RS2[i]));
            check($sformatf("v%0d_imm", i), imm, V_IMM[i]);
            check($sformatf("v%0d_alu", i), 32'(alu_op), 32'(V_ALU[i]));
            check($sformatf("v%0d_flags", i), 32'(flags), 32'(V_FLG[i]));
        end
        tick();
        check("drained_valid", 32'(valid_out), 32'd0);

        // Back-to-back stream: one per cycle, ready never drops.
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                check($sformatf("tp%0d_valid", k), 32'(valid_out), 32'd1);
                check($sformatf("tp%0d_pc", k), pc_out, 32'h400 + 32'(4 * (k - 2)));
            end
            if (k < 4) begin
                check($sformatf("tp%0d_ready", k), 32'(ready_out), 32'd1);
                valid_in = 1'b1;
                instr_in = 32'h00000013 | (32'(k + 1) << 7);
                pc_in    = 32'h400 + 32'(4 * k);
            end else begin
                valid_in = 1'b0;
            end
            tick();
        end
        tick();
        check("tp_drained", 32'(valid_out), 32'd0);

        // Backpressure: queue fills, outputs hold, then drain in order.
        ready_in = 1'b0;
        send(32'h00100193, 32'h200);
        send(32'h00200213, 32'h204);
        send(32'h00300293, 32'h208);
        check("bp_ready_low", 32'(ready_out), 32'd0);
        valid_in = 1'b1; instr_in = 32'h00400313; pc_in = 32'h20C;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold%0d_pc", k), pc_out, 32'h200);
            check($sformatf("bp_hold%0d_rd", k), 32'(rd), 32'd3);
            check($sformatf("bp_hold%0d_ready", k), 32'(ready_out), 32'd0);
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_drain%0d_valid", k), 32'(valid_out), 32'd1);
            check($sformatf("bp_drain%0d_pc", k), pc_out, 32'h200 + 32'(4 * k));
            check($sformatf("bp_drain%0d_rd", k), 32'(rd), 32'(3 + k));
            tick();
        end
        check("bp_no_extra", 32'(valid_out), 32'd0);

        // Flush with a full queue and a held output bundle.
        ready_in = 1'b0;
        send(32'h00100193, 32'h300);
        send(32'h00200213, 32'h304);
        send(32'h00300293, 32'h308);
        check("fl_full", 32'(ready_out), 32'd0);
        flush = 1'b1; valid_in = 1'b1; instr_in = 32'h00700393; pc_in = 32'h3F0;
        tick();
        flush = 1'b0; valid_in = 1'b0;
        check("fl_valid", 32'(valid_out), 32'd0);
        check("fl_ready", 32'(ready_out), 32'd1);
        ready_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("fl_empty%0d", k), 32'(valid_out), 32'd0);
        end
        // Flush while ready is high: the offered instruction must be dropped.
        flush = 1'b1; valid_in = 1'b1; instr_in = 32'h00800413; pc_in = 32'h3F4;
        tick();
        flush = 1'b0; valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("fl_drop%0d", k), 32'(valid_out), 32'd0);
            tick();
        end

        // Asynchronous reset in the middle of a stream.
        send(V_INSTR[0], 32'h500);
        send(V_INSTR[5], 32'h504);
        check("ar_pre_valid", 32'(valid_out), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", 32'(valid_out), 32'd0);
        check("ar_ready", 32'(ready_out), 32'd1);
        check("ar_pc", pc_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("ar_discarded", 32'(valid_out), 32'd0);
        send(V_INSTR[5], 32'h600);
        tick();
        check("ar_new_valid", 32'(valid_out), 32'd1);
        check("ar_new_pc", pc_out, 32'h600);
        check("ar_new_rd", 32'(rd), 32'd3);
        check("ar_new_alu", 32'(alu_op), 32'(SUB));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
